// File: rtl/gcd_arbiter.sv
// Round-robin arbiter that shares a single gcd engine among NUM_REQ requesters.
// Optional feature: define GCD_ARB_ZERO_BYPASS_EN to answer zero-operand pairs without the engine.
module gcd_arbiter #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned WIDTH   = 16
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [NUM_REQ-1:0]         req_valid,
  input  logic [NUM_REQ*WIDTH-1:0]   req_a,
  input  logic [NUM_REQ*WIDTH-1:0]   req_b,
  output logic [NUM_REQ-1:0]         req_ready,
  output logic [NUM_REQ-1:0]         rsp_valid,
  output logic [WIDTH-1:0]           rsp_data,
  output logic [$clog2(NUM_REQ)-1:0] rsp_id,
  output logic                       busy,
  output logic                       eng_start,
  output logic [WIDTH-1:0]           eng_in1,
  output logic [WIDTH-1:0]           eng_in2,
  input  logic [WIDTH-1:0]           eng_gcd,
  input  logic                       eng_done
);

  localparam int unsigned IdW = $clog2(NUM_REQ);

  typedef enum logic [2:0] {StIdle, StIssue, StArm, StWait, StResp} state_e;

  state_e             state_q, state_d;
  logic [IdW-1:0]     rr_ptr_q, rr_ptr_d;
  logic [IdW-1:0]     cur_id_q, cur_id_d;
  logic [WIDTH-1:0]   op_a_q, op_a_d;
  logic [WIDTH-1:0]   op_b_q, op_b_d;
  logic [WIDTH-1:0]   res_q, res_d;
  logic               busy_q, busy_d;
  logic               eng_start_q, eng_start_d;
  logic [NUM_REQ-1:0] rsp_valid_q, rsp_valid_d;
  logic [WIDTH-1:0]   rsp_data_q, rsp_data_d;
  logic [IdW-1:0]     rsp_id_q, rsp_id_d;

  logic               gnt_found;
  logic [IdW-1:0]     gnt_id;
  logic [IdW-1:0]     cand;
  logic [WIDTH-1:0]   gnt_a, gnt_b;

  // First valid requester at or after rr_ptr, wrapping around.
  always_comb begin
    gnt_found = 1'b0;
    gnt_id    = '0;
    cand      = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      cand = IdW'((int'(rr_ptr_q) + k) % NUM_REQ);
      if (!gnt_found && req_valid[cand]) begin
        gnt_found = 1'b1;
        gnt_id    = cand;
      end
    end
  end

  assign gnt_a = req_a[int'(gnt_id)*WIDTH +: WIDTH];
  assign gnt_b = req_b[int'(gnt_id)*WIDTH +: WIDTH];

  // The accept pulse must be visible in the same cycle as the grant decision.
  assign req_ready = (state_q == StIdle && gnt_found) ? (NUM_REQ'(1) << gnt_id) : '0;

  always_comb begin
    state_d  = state_q;
    rr_ptr_d = rr_ptr_q;
    cur_id_d = cur_id_q;
    op_a_d   = op_a_q;
    op_b_d   = op_b_q;
    res_d    = res_q;
    unique case (state_q)
      StIdle: begin
        if (gnt_found) begin
          op_a_d   = gnt_a;
          op_b_d   = gnt_b;
          cur_id_d = gnt_id;
          rr_ptr_d = (gnt_id == IdW'(NUM_REQ - 1)) ? '0 : gnt_id + 1'b1;
`ifdef GCD_ARB_ZERO_BYPASS_EN
          if (gnt_a == '0 || gnt_b == '0) begin
            res_d   = gnt_a | gnt_b;
            state_d = StResp;
          end else begin
            state_d = StIssue;
          end
`else
          state_d = StIssue;
`endif
        end
      end
      StIssue: state_d = StArm;
      // A done level left over from the previous operation must drop first.
      StArm: begin
        if (!eng_done) state_d = StWait;
      end
      StWait: begin
        if (eng_done) begin
          res_d   = eng_gcd;
          state_d = StResp;
        end
      end
      StResp:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Outputs are registered from the next state so they line up with it.
  always_comb begin
    busy_d      = (state_d != StIdle);
    eng_start_d = (state_d == StIssue);
    rsp_valid_d = '0;
    rsp_data_d  = rsp_data_q;
    rsp_id_d    = rsp_id_q;
    if (state_d == StResp) begin
      rsp_valid_d = NUM_REQ'(1) << cur_id_d;
      rsp_data_d  = res_d;
      rsp_id_d    = cur_id_d;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= StIdle;
      rr_ptr_q    <= '0;
      cur_id_q    <= '0;
      op_a_q      <= '0;
      op_b_q      <= '0;
      res_q       <= '0;
      busy_q      <= 1'b0;
      eng_start_q <= 1'b0;
      rsp_valid_q <= '0;
      rsp_data_q  <= '0;
      rsp_id_q    <= '0;
    end else begin
      state_q     <= state_d;
      rr_ptr_q    <= rr_ptr_d;
      cur_id_q    <= cur_id_d;
      op_a_q      <= op_a_d;
      op_b_q      <= op_b_d;
      res_q       <= res_d;
      busy_q      <= busy_d;
      eng_start_q <= eng_start_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
      rsp_id_q    <= rsp_id_d;
    end
  end

  assign busy      = busy_q;
  assign eng_start = eng_start_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_data  = rsp_data_q;
  assign rsp_id    = rsp_id_q;
  assign eng_in1   = op_a_q;
  assign eng_in2   = op_b_q;

endmodule
